// File: rtl/cassette_fsk_demod.sv
// rtl/cassette_fsk_demod.sv - cassette FSK (1200/2400 Hz) bit demodulator
//
// Ports:
//   clk           in   fast clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   cas_in        in   raw asynchronous comparator input
//   enable        in   motor-on; 0 holds the decoder idle
//   reverse_tones in   inverts the data sense of rx_bit
//   rx_bit        out  last decoded bit (valid with rx_valid, held between strobes)
//   rx_valid      out  one-clk strobe per decoded bit
//   carrier       out  tone present and decoding
//   high_tone     out  sustained high-tone run-in detected

module cassette_fsk_demod #(
   parameter int TICK_DIV     = 2,
   parameter int FILTER_BITS  = 2,
   parameter int GAP_BITS     = 9,
   parameter int LONG_GAP     = 176,
   parameter int HT_DIV       = 256,
   parameter int HT_BITS      = 10,
   parameter int HT_THRESHOLD = 962
) (
   input  logic clk,
   input  logic rst,
   input  logic cas_in,
   input  logic enable,
   input  logic reverse_tones,
   output logic rx_bit,
   output logic rx_valid,
   output logic carrier,
   output logic high_tone
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HT_DIV > 1) ? $clog2(HT_DIV) : 1;

   localparam logic [TW-1:0]          TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0]          HT_LAST   = HW'(HT_DIV - 1);
   localparam logic [FILTER_BITS-1:0] FILT_FULL = '1;
   localparam logic [GAP_BITS-1:0]    GAP_MAX   = '1;
   localparam logic [GAP_BITS-1:0]    GAP_PRE   = GAP_MAX - GAP_BITS'(1);
   localparam logic [GAP_BITS-1:0]    LONG_V    = GAP_BITS'(LONG_GAP);
   localparam logic [HT_BITS-1:0]     HT_MAX    = '1;
   localparam logic [HT_BITS-1:0]     HT_THR    = HT_BITS'(HT_THRESHOLD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HALF = 2'd2
   } state_t;

   logic                   sync1, sync2;
   logic [TW-1:0]          tick_cnt;
   logic                   tick;
   logic                   filt;
   logic [FILTER_BITS-1:0] fcnt;
   logic                   edge_det;
   logic [GAP_BITS-1:0]    gap;
   logic                   is_long;
   logic                   sat_evt;
   state_t                 state;
   logic                   emit;
   logic                   dec;
   logic                   last_dec;
   logic [HW-1:0]          ht_div_cnt;
   logic                   ht_tick;
   logic [HT_BITS-1:0]     ht_cnt;
   logic [HT_BITS-1:0]     ht_next;

   // Two-flop synchroniser for the asynchronous comparator input.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= cas_in;
         sync2 <= sync1;
      end
   end

   // Free-running sample tick divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // The edge fires on the tick where the count is already full and the
   // input still disagrees, i.e. the 2^FILTER_BITS-th disagreeing tick.
   assign edge_det = tick && (sync2 != filt) && (fcnt == FILT_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= 1'b0;
         fcnt <= '0;
      end else if (tick) begin
         if (sync2 == filt) begin
            fcnt <= '0;
         end else if (fcnt == FILT_FULL) begin
            filt <= ~filt;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + FILTER_BITS'(1);
         end
      end
   end

   // Saturating edge-gap counter in ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap <= '0;
      end else if (tick) begin
         if (edge_det) begin
            gap <= '0;
         end else if (gap != GAP_MAX) begin
            gap <= gap + GAP_BITS'(1);
         end
      end
   end

   assign is_long = (gap >= LONG_V);

   // Saturation event is the tick on which the gap reaches (or sits at) its
   // maximum with no edge; an edge on the same tick takes priority.
   assign sat_evt = tick && !edge_det && (gap >= GAP_PRE);

   // Decision for the current edge: WAIT+long gives 0, HALF gives 1 for a
   // second short half-cycle or 0 for a long one (realignment).
   always_comb begin
      emit = 1'b0;
      dec  = 1'b0;
      if (enable && edge_det) begin
         case (state)
            S_WAIT: begin
               emit = is_long;
               dec  = 1'b0;
            end
            S_HALF: begin
               emit = 1'b1;
               dec  = ~is_long;
            end
            default: begin
               emit = 1'b0;
               dec  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rx_bit   <= 1'b0;
         rx_valid <= 1'b0;
         carrier  <= 1'b0;
         last_dec <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (!enable) begin
            state   <= S_IDLE;
            carrier <= 1'b0;
         end else if (edge_det) begin
            case (state)
               S_IDLE:  state <= S_WAIT;
               S_WAIT:  state <= is_long ? S_WAIT : S_HALF;
               S_HALF:  state <= S_WAIT;
               default: state <= S_IDLE;
            endcase
            if (emit) begin
               rx_valid <= 1'b1;
               rx_bit   <= dec ^ reverse_tones;
               last_dec <= dec;
               carrier  <= 1'b1;
            end
         end else if (sat_evt && state != S_IDLE) begin
            state   <= S_IDLE;
            carrier <= 1'b0;
         end
      end
   end

   // High-tone tick divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         ht_div_cnt <= '0;
      end else if (ht_div_cnt == HT_LAST) begin
         ht_div_cnt <= '0;
      end else begin
         ht_div_cnt <= ht_div_cnt + HW'(1);
      end
   end

   assign ht_tick = (ht_div_cnt == HT_LAST);

   // A run of 1 bits with carrier present counts up; any 0 bit or loss of
   // carrier restarts the run.
   always_comb begin
      ht_next = ht_cnt;
      if (!last_dec || !carrier) begin
         ht_next = '0;
      end else if (ht_cnt != HT_MAX) begin
         ht_next = ht_cnt + HT_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ht_cnt    <= '0;
         high_tone <= 1'b0;
      end else begin
         if (!enable) begin
            ht_cnt <= '0;
         end else if (ht_tick) begin
            ht_cnt <= ht_next;
         end
         if (ht_tick) begin
            high_tone <= enable && (ht_next >= HT_THR);
         end
      end
   end

endmodule

// File: doc/cassette_fsk_demod.md
CASSETTE_FSK_DEMOD -- requirements
Module: cassette_fsk_demod

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 2, meaning the number of clk cycles per sample tick (minimum 1).
REQ-002 The block SHALL have parameter FILTER_BITS, default 2, meaning the glitch-filter counter width; an input change is accepted after 2^FILTER_BITS disagreeing ticks.
REQ-003 The block SHALL have parameter GAP_BITS, default 9, meaning the width of the saturating edge-gap counter, in ticks.
REQ-004 The block SHALL have parameter LONG_GAP, default 176, meaning the gap in ticks at or above which a half-cycle is classed long.
REQ-005 The block SHALL have parameters HT_DIV (default 256, clk cycles per high-tone tick), HT_BITS (default 10) and HT_THRESHOLD (default 962).
REQ-006 The block SHALL have port clk  in  1  fast clock (16/13 MHz); all logic is clocked on its rising edge.
REQ-007 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-008 The block SHALL have port cas_in  in  1  raw asynchronous cassette comparator input.
REQ-009 The block SHALL have port enable  in  1  motor-on; 0 holds the decoder idle.
REQ-010 The block SHALL have port reverse_tones  in  1  inverts the data sense of rx_bit.
REQ-011 The block SHALL have port rx_bit  out  1  last decoded bit, valid when rx_valid is 1.
REQ-012 The block SHALL have port rx_valid  out  1  one-clk strobe per decoded bit.
REQ-013 The block SHALL have port carrier  out  1  tone present and decoding.
REQ-014 The block SHALL have port high_tone  out  1  sustained high-tone run-in detected.

Function
REQ-015 cas_in SHALL pass through a 2-flop synchroniser on clk before any other use.
REQ-016 The tick SHALL be a one-clk pulse every TICK_DIV clk cycles, generated by a free-running modulo-TICK_DIV counter.
REQ-017 Filter, on each tick: if the synchronised input equals the filtered value, clear the filter count; otherwise increment it, and when the count is all-ones, toggle the filtered value, clear the count and assert edge for that tick only.
REQ-018 Gap counter, on each tick: cleared to 0 on edge, otherwise incremented and saturating at 2^GAP_BITS-1.
REQ-019 On edge, the half-cycle SHALL be classed long if gap >= LONG_GAP and short otherwise, using the gap value before it is cleared.
REQ-020 The decoder SHALL have states IDLE, WAIT and HALF.
- IDLE, on edge: go to WAIT with no decision, since the first gap is unmeasured.
- WAIT, long: emit 0 and stay in WAIT.
- WAIT, short: go to HALF.
- HALF, short: emit 1 and go to WAIT.
- HALF, long: emit 0 and go to WAIT, which realigns the decoder.
REQ-021 In WAIT or HALF, if the gap counter saturates, the decoder SHALL go to IDLE, drop any pending half-cycle and clear carrier, with no rx_valid.
REQ-022 Emit SHALL mean: rx_valid=1 for exactly one clk, rx_bit = decoded ^ reverse_tones, with reverse_tones sampled that cycle; rx_bit holds its value between strobes.
REQ-023 carrier SHALL set on the first emit after IDLE and clear on entry to IDLE.
REQ-024 enable=0 SHALL force the decoder to IDLE, carrier=0 and the high-tone counter to 0; the synchroniser, filter and gap counter keep running.
REQ-025 High-tone counter, on each HT tick (every HT_DIV clk):
- clear it if the last decoded bit, before reversal, is 0 or carrier is 0;
- otherwise increment it, saturating at 2^HT_BITS-1.
REQ-026 high_tone SHALL be 1 whenever the high-tone counter is >= HT_THRESHOLD, registered on the HT tick.
REQ-027 When edge and gap saturation occur in the same tick, edge SHALL win: the half-cycle is classed long and decoded normally.
REQ-028 Latency SHALL be: cas_in edge to internal edge = 2 clk + 2^FILTER_BITS ticks (+ tick phase); decoding edge to rx_valid = 1 clk.

Reset
REQ-029 While rst=1, all of the following SHALL reset:
- state -> IDLE;
- tick, filter, gap and HT counters -> 0;
- synchroniser and filtered value -> 0;
- rx_bit, rx_valid, carrier, high_tone -> 0.
REQ-030 A reset asserted mid-bit SHALL discard any pending half-cycle, and no rx_valid SHALL be produced for it.

Verification
REQ-031 A 2400 Hz square wave (256-clk halves), enable=1, defaults -> after the 2nd edge, alternating WAIT/HALF; rx_valid every 512 clk with rx_bit=1; carrier=1.
REQ-032 A 1200 Hz square wave (512-clk halves) -> rx_valid every 512 clk with rx_bit=0; with reverse_tones=1 -> rx_bit=1.
REQ-033 2400 Hz held for 962*256 clk after carrier -> high_tone=1; a single 1200 Hz half-cycle -> counter cleared, high_tone=0 at the next HT tick.
REQ-034 cas_in frozen after decoding -> once 511 ticks (1022 clk) elapse after the last edge, carrier=0 and state IDLE, with no extra rx_valid.
REQ-035 A 3-tick glitch (6 clk) on a steady input -> no edge and no rx_valid; a 4-tick change -> edge.
REQ-036 rst or enable=0 asserted in HALF -> IDLE, carrier=0, no rx_valid; after release, the first edge yields no bit.
